// File: rtl/ps2_pkg.sv
// Shared PS/2 scan codes, receiver state type and frame validity helper.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_e;

  // Frame layout as shifted in: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
  // Odd parity: data bits plus parity bit contain an odd number of 1s.
  function automatic logic frame_ok(input logic [10:0] frame);
    return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1]);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter,
// 11-bit shifter with start/stop/parity check, and mid-frame watchdog.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_f_q,     clk_f_d;
  logic [FW-1:0] filt_cnt_q,  filt_cnt_d;
  rx_state_e     state_q,     state_d;
  logic [3:0]    bitcnt_q,    bitcnt_d;
  logic [10:0]   shreg_q,     shreg_d;
  logic [WW-1:0] wdog_q,      wdog_d;
  logic [7:0]    rx_byte_q,   rx_byte_d;
  logic          rx_valid_q,  rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          fall;
  logic          dat_s;

  assign dat_s     = dat_sync_q[1];
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

  // Two-flop synchronisers; both lines idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive opposite samples.
  always_comb begin
    clk_f_d    = clk_f_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_sync_q[1] == clk_f_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      clk_f_d    = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall = clk_f_q && !clk_f_d;

  // Receiver FSM next state. The frame is judged on the 11th edge so the
  // registered strobes are high during the single CHECK cycle.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    wdog_d      = wdog_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (fall) begin
          shreg_d  = {dat_s, shreg_q[10:1]};
          bitcnt_d = 4'd1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          shreg_d  = {dat_s, shreg_q[10:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          wdog_d   = '0;
          if (bitcnt_q == 4'd10) begin
            state_d = CHECK;
            if (frame_ok(shreg_d)) begin
              rx_byte_d  = shreg_d[8:1];
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          bitcnt_d    = '0;
          wdog_d      = '0;
          frame_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      CHECK: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

  // Filter, FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f_q     <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      wdog_q      <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_f_q     <= clk_f_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      wdog_q      <= wdog_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: rtl/ps2_color_ctrl.sv
// PS/2 keyboard to colour-enable controller: R/G/B keys toggle their
// colour once per press, space clears all three.
module ps2_color_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  logic brk_q,    brk_d;
  logic ext_q,    ext_d;
  logic held_r_q, held_r_d;
  logic held_g_q, held_g_d;
  logic held_b_q, held_b_d;
  logic red_q,    red_d;
  logic green_q,  green_d;
  logic blue_q,   blue_d;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

  // Scan-code decoder with break/extended prefix tracking.
  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    held_r_d = held_r_q;
    held_g_d = held_g_q;
    held_b_d = held_b_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          if (brk_q) begin
            if (rx_byte == SC_R) held_r_d = 1'b0;
            if (rx_byte == SC_G) held_g_d = 1'b0;
            if (rx_byte == SC_B) held_b_d = 1'b0;
          end else begin
            if (rx_byte == SC_R) begin
              if (!held_r_q) red_d = !red_q;
              held_r_d = 1'b1;
            end
            if (rx_byte == SC_G) begin
              if (!held_g_q) green_d = !green_q;
              held_g_d = 1'b1;
            end
            if (rx_byte == SC_B) begin
              if (!held_b_q) blue_d = !blue_q;
              held_b_d = 1'b1;
            end
            if (rx_byte == SC_SPACE) begin
              red_d   = 1'b0;
              green_d = 1'b0;
              blue_d  = 1'b0;
            end
          end
        end
      end
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      held_r_q <= 1'b0;
      held_g_q <= 1'b0;
      held_b_q <= 1'b0;
      red_q    <= 1'b0;
      green_q  <= 1'b0;
      blue_q   <= 1'b0;
    end else begin
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      held_r_q <= held_r_d;
      held_g_q <= held_g_d;
      held_b_q <= held_b_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

endmodule

// File: tb/tb_ps2_color_ctrl.sv
// Self-checking bench for ps2_color_ctrl with a received-byte scoreboard.
module tb_ps2_color_ctrl;

  localparam int unsigned HALF = 40;
  localparam int unsigned TMO  = 500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       red, green, blue;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  logic prev_valid = 1'b0;

  ps2_color_ctrl #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #20 clk = ~clk;

  // Scoreboard: every rx_valid strobe must match the oldest expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rx_valid && frame_err) begin
      total++; bad++;
      $display("FAIL strobe_overlap rx_valid=1 frame_err=1 required not both");
    end
    if (rx_valid && prev_valid) begin
      total++; bad++;
      $display("FAIL valid_width rx_valid high 2 cycles, required 1");
    end
    if (rx_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte got=%h required none", rx_byte);
      end else begin
        e = exp_q.pop_front();
        if (rx_byte !== e) begin
          bad++;
          $display("FAIL rx_byte got=%h required=%h", rx_byte, e);
        end
      end
    end
    if (frame_err) err_cnt++;
    prev_valid = rx_valid;
  end

  initial begin
    #10ms;
    $display("FAIL global_timeout simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    cycles(HALF / 2);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      cycles(8);
      ps2_clk = 1'b0;
      cycles(3);
      ps2_clk = 1'b1;
      cycles(HALF / 2 - 11 + 10);
    end else begin
      cycles(HALF / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    if (!bad_par) exp_q.push_back(b);
    for (int i = 0; i < 11; i++) send_bit(f[i], glitch);
    ps2_data = 1'b1;
    cycles(40);
  endtask

  // First n bits of the 0x2D frame, then the clock stays high.
  task automatic send_partial(input int n);
    logic [10:0] f;
    f = {1'b1, 1'b1, 8'h2D, 1'b0};
    for (int i = 0; i < n; i++) send_bit(f[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic check_rgb(input logic [2:0] exp, input string name);
    @(negedge clk);
    total++;
    if ({red, green, blue} !== exp) begin
      bad++;
      $display("FAIL %s rgb=%b required=%b", name, {red, green, blue}, exp);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_rx pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cycles(5);
    @(negedge clk);
    total++;
    if ({red, green, blue, rx_byte, rx_valid, frame_err} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b required=0",
               {red, green, blue, rx_byte, rx_valid, frame_err});
    end
    rst_n = 1'b1;
    cycles(20);
  endtask

  task automatic test_single;
    int n;
    fork
      send_frame(8'h2D, 1'b0, 1'b0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!rx_valid && n < 3000);
        total++;
        if (!rx_valid) begin
          bad++;
          $display("FAIL single_wait rx_valid=0 required=1 within 3000 cycles");
        end else begin
          total++;
          if (red !== 1'b0) begin bad++; $display("FAIL red_before got=%b required=0", red); end
          @(negedge clk);
          total++;
          if (red !== 1'b1) begin bad++; $display("FAIL red_after got=%b required=1", red); end
        end
      end
    join
    check_drained("single");
  endtask

  task automatic test_typematic;
    send_frame(8'h2D, 1'b0, 1'b0); check_rgb(3'b100, "repeat1");
    send_frame(8'h2D, 1'b0, 1'b0); check_rgb(3'b100, "repeat2");
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h2D, 1'b0, 1'b0); check_rgb(3'b100, "break_r");
    send_frame(8'h2D, 1'b0, 1'b0); check_rgb(3'b000, "retoggle_r");
    check_drained("typematic");
  endtask

  task automatic test_gbs_ext;
    send_frame(8'h34, 1'b0, 1'b0); check_rgb(3'b010, "make_g");
    send_frame(8'h32, 1'b0, 1'b0); check_rgb(3'b011, "make_b");
    send_frame(8'h29, 1'b0, 1'b0); check_rgb(3'b000, "space");
    send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h34, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h32, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h2D, 1'b0, 1'b0);
    check_rgb(3'b000, "breaks");
    send_frame(8'hE0, 1'b0, 1'b0); send_frame(8'h2D, 1'b0, 1'b0);
    check_rgb(3'b000, "ext_ignored");
    check_drained("gbs_ext");
  endtask

  task automatic test_parity;
    int e0;
    send_frame(8'h29, 1'b0, 1'b0);
    e0 = err_cnt;
    send_frame(8'h2D, 1'b1, 1'b0);
    total++;
    if (err_cnt !== e0 + 1) begin
      bad++; $display("FAIL parity_err count=%0d required=%0d", err_cnt - e0, 1);
    end
    total++;
    if (rx_byte !== 8'h29) begin
      bad++; $display("FAIL parity_byte got=%h required=29", rx_byte);
    end
    check_rgb(3'b000, "parity_rgb");
    check_drained("parity");
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    send_partial(5);
    cycles(TMO + 100);
    total++;
    if (err_cnt !== e0 + 1) begin
      bad++; $display("FAIL timeout_err count=%0d required=%0d", err_cnt - e0, 1);
    end
    send_frame(8'h32, 1'b0, 1'b0);
    check_rgb(3'b001, "after_timeout");
    check_drained("timeout");
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_cnt;
    send_frame(8'h34, 1'b0, 1'b1);
    check_rgb(3'b011, "glitch_rgb");
    total++;
    if (err_cnt !== e0) begin
      bad++; $display("FAIL glitch_err count=%0d required=0", err_cnt - e0);
    end
    check_drained("glitch");
  endtask

  task automatic test_reset_midframe;
    send_partial(5);
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    total++;
    if ({red, green, blue, rx_byte, rx_valid, frame_err} !== 13'b0) begin
      bad++;
      $display("FAIL async_reset got=%b required=0",
               {red, green, blue, rx_byte, rx_valid, frame_err});
    end
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    send_frame(8'h2D, 1'b0, 1'b0);
    check_rgb(3'b100, "after_reset");
    check_drained("reset_midframe");
  endtask

  initial begin
    test_reset();
    test_single();
    test_typematic();
    test_gbs_ext();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
